// File: rtl/bcd_convert_ctrl.sv
// 8-bit binary to 3-digit BCD converter using the double-dabble algorithm.
// Fixed 10-cycle conversion period: accept, 8 shift cycles, one done cycle.
module bcd_convert_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [11:0] scr_q, scr_adj, scr_d;
    logic [7:0]  opr_q, opr_d;
    logic [3:0]  cnt_q;
    logic        busy_q, done_q;
    logic [11:0] bcd_q;

    // Add-3 correction on each digit, then shift {scratch, operand} left one bit.
    always_comb begin
        scr_adj = scr_q;
        for (int d = 0; d < 3; d++) begin
            if (scr_q[d*4 +: 4] >= 4'd5)
                scr_adj[d*4 +: 4] = scr_q[d*4 +: 4] + 4'd3;
        end
        scr_d = {scr_adj[10:0], opr_q[7]};
        opr_d = {opr_q[6:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scr_q   <= '0;
            opr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opr_q   <= bin;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    opr_q <= opr_d;
                    cnt_q <= cnt_q + 4'd1;
                    // Last iteration: publish the freshly shifted scratch.
                    if (cnt_q == 4'd7) begin
                        bcd_q   <= scr_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed self-checking bench for bcd_convert_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bcd_convert_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy, done;
    logic [11:0] bcd;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          done_no_busy = 0;
    logic [11:0] prev_bcd;

    always #5 clk = ~clk;

    bcd_convert_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b1) done_no_busy++;
        end
    end

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge 10 cycles later,
    // so consecutive calls accept back-to-back.
    task automatic run_conv(input logic [7:0] v);
        logic [11:0] exp;
        exp   = ref_bcd(int'(v));
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = ~v;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("busy[%0d] k%0d", v, k), busy, (k <= 9));
            chk($sformatf("done[%0d] k%0d", v, k), done, (k == 9));
            chk($sformatf("bcd[%0d] k%0d", v, k), bcd, (k >= 9) ? exp : prev_bcd);
        end
        prev_bcd = exp;
    endtask

    initial begin
        logic [7:0] bnd [7];
        int         done_at [$];
        logic [11:0] bcd_at [$];
        int         base;

        bnd = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200};
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        prev_bcd = 12'h000;

        // Reset state
        #12;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst bcd", bcd, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single conversion with full timing check
        run_conv(8'd255);

        // Digit boundaries
        for (int i = 0; i < 7; i++) run_conv(bnd[i]);

        // start held for 20 cycles, bin changes mid-conversion
        start = 1'b1;
        bin   = 8'd42;
        for (int s = 1; s <= 30; s++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_at.push_back(s);
                bcd_at.push_back(bcd);
            end
            if (s == 3)  bin   = 8'd7;
            if (s == 20) start = 1'b0;
        end
        chk("hold done count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            chk("hold done1 cycle", done_at[0], 9);
            chk("hold bcd1", bcd_at[0], 12'h042);
            chk("hold done2 cycle", done_at[1], 19);
            chk("hold bcd2", bcd_at[1], 12'h007);
        end
        prev_bcd = 12'h007;

        // Reset during SHIFT
        start = 1'b1;
        bin   = 8'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst bcd", bcd, 12'h000);
        prev_bcd = 12'h000;
        base = done_cnt;
        repeat (2) @(negedge clk);
        chk("midrst no done", done_cnt - base, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(8'd123);

        // Exhaustive sweep, back-to-back
        base = done_cnt;
        for (int v = 0; v < 256; v++) run_conv(8'(v));
        chk("sweep done count", done_cnt - base, 256);
        chk("done without busy", done_no_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
